// File: rtl/keypad_entry.sv
// Keypad digit entry for a cooking timer: shifts BCD digits in per key press
// and hands them to the timer counters with a one-cycle active-low load strobe.
module keypad_entry (
  input  logic       clock,
  input  logic       clr,
  input  logic [9:0] key,
  input  logic       enable,
  input  logic       start,
  output logic [3:0] mins,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       loadn,
  output logic       err,
  output logic [1:0] count
);

  typedef enum logic [1:0] {IDLE, HELD, LOAD} state_t;

  state_t     state_reg, state_next;
  logic [3:0] mins_reg, mins_next;
  logic [3:0] tens_reg, tens_next;
  logic [3:0] ones_reg, ones_next;
  logic [1:0] count_reg, count_next;
  logic       loadn_reg, loadn_next;
  logic       err_reg, err_next;

  logic [3:0] key_idx;
  logic [3:0] key_pop;

  // Index of the highest pressed key and number of keys pressed; the index is
  // only used when exactly one key is down, so it is always a legal digit.
  always_comb begin
    key_idx = 4'd0;
    key_pop = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) begin
        key_idx = 4'(i);
        key_pop = key_pop + 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mins_next  = mins_reg;
    tens_next  = tens_reg;
    ones_next  = ones_reg;
    count_next = count_reg;
    loadn_next = 1'b1;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key != 10'd0) begin
          state_next = HELD;
          if (enable && key_pop == 4'd1) begin
            mins_next  = tens_reg;
            tens_next  = ones_reg;
            ones_next  = key_idx;
            count_next = (count_reg == 2'd3) ? 2'd3 : count_reg + 2'd1;
          end
        end else if (start && enable && count_reg != 2'd0) begin
          // A seconds-tens digit above 5 is not a valid time.
          if (tens_reg <= 4'd5) begin
            state_next = LOAD;
            loadn_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      HELD: begin
        if (key == 10'd0) state_next = IDLE;
      end
      LOAD: begin
        mins_next  = 4'd0;
        tens_next  = 4'd0;
        ones_next  = 4'd0;
        count_next = 2'd0;
        state_next = (key != 10'd0) ? HELD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state_reg <= IDLE;
      mins_reg  <= 4'd0;
      tens_reg  <= 4'd0;
      ones_reg  <= 4'd0;
      count_reg <= 2'd0;
      loadn_reg <= 1'b1;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      mins_reg  <= mins_next;
      tens_reg  <= tens_next;
      ones_reg  <= ones_next;
      count_reg <= count_next;
      loadn_reg <= loadn_next;
      err_reg   <= err_next;
    end
  end

  assign mins  = mins_reg;
  assign tens  = tens_reg;
  assign ones  = ones_reg;
  assign count = count_reg;
  assign loadn = loadn_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: a queue-of-digits reference model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_keypad_entry;

  logic       clock;
  logic       clr;
  logic [9:0] key;
  logic       enable;
  logic       start;
  logic [3:0] mins, tens, ones;
  logic       loadn, err;
  logic [1:0] count;

  keypad_entry dut (
    .clock(clock), .clr(clr), .key(key), .enable(enable), .start(start),
    .mins(mins), .tens(tens), .ones(ones), .loadn(loadn), .err(err), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the entered digits as a queue (newest last, at most three),
  // whether the keypad has been released since the last press, and a pending load.
  int q[$];
  bit armed = 1;
  bit loading = 0;
  bit m_err = 0;
  bit m_loadn = 1;

  function automatic int dig(int pos);
    if (q.size() > pos) return q[q.size() - 1 - pos];
    return 0;
  endfunction

  always @(posedge clock) begin
    if (clr) begin
      q.delete(); armed = 1; loading = 0; m_err = 0; m_loadn = 1;
    end else if (loading) begin
      q.delete(); loading = 0; armed = (key == 10'd0); m_err = 0; m_loadn = 1;
    end else begin
      m_err = 0;
      if (!armed) begin
        if (key == 10'd0) armed = 1;
      end else if (key != 10'd0) begin
        armed = 0;
        if (enable && $countones(key) == 1) begin
          q.push_back($clog2(key));
          if (q.size() > 3) void'(q.pop_front());
        end
      end else if (start && enable && q.size() > 0) begin
        if (dig(1) <= 5) begin
          loading = 1; m_loadn = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_ones", 8'(ones), 8'(dig(0)));
      chk("model_tens", 8'(tens), 8'(dig(1)));
      chk("model_mins", 8'(mins), 8'(dig(2)));
      chk("model_count", 8'(count), 8'(q.size()));
      chk("model_loadn", 8'(loadn), 8'(m_loadn));
      chk("model_err", 8'(err), 8'(m_err));
    end
  end

  task automatic cyc(input logic [9:0] k, input logic en, input logic st, input logic c);
    key = k; enable = en; start = st; clr = c;
    @(negedge clock);
  endtask

  task automatic press(input int d);
    cyc(10'b1 << d, 1'b1, 1'b0, 1'b0);
    cyc(10'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_all(input string name, input int m, input int t, input int o,
                            input int c, input int ld, input int e);
    chk({name, "_mins"}, 8'(mins), 8'(m));
    chk({name, "_tens"}, 8'(tens), 8'(t));
    chk({name, "_ones"}, 8'(ones), 8'(o));
    chk({name, "_count"}, 8'(count), 8'(c));
    chk({name, "_loadn"}, 8'(loadn), 8'(ld));
    chk({name, "_err"}, 8'(err), 8'(e));
  endtask

  initial begin
    logic [9:0] prev;
    logic [9:0] k;
    int r;
    key = 10'd0; enable = 1'b1; start = 1'b0; clr = 1'b1;
    @(negedge clock);
    cyc(10'd0, 1'b1, 1'b0, 1'b1);
    chk_en = 1;
    expect_all("reset", 0, 0, 0, 0, 1, 0);

    // Press 1, 3, 0 then start: one load strobe, then everything cleared.
    press(1); press(3); press(0);
    expect_all("p130", 1, 3, 0, 3, 1, 0);
    cyc(10'd0, 1'b1, 1'b1, 1'b0);
    expect_all("p130_load", 1, 3, 0, 3, 0, 0);
    cyc(10'd0, 1'b1, 1'b0, 1'b0);
    expect_all("p130_after", 0, 0, 0, 0, 1, 0);

    // Press 9, 9 then start: seconds-tens of 9 is rejected.
    cyc(10'd0, 1'b1, 1'b0, 1'b1);
    press(9); press(9);
    cyc(10'd0, 1'b1, 1'b1, 1'b0);
    expect_all("p99_err", 0, 9, 9, 2, 1, 1);
    cyc(10'd0, 1'b1, 1'b0, 1'b0);
    expect_all("p99_after", 0, 9, 9, 2, 1, 0);

    // Long hold of 5 captures once.
    cyc(10'd0, 1'b1, 1'b0, 1'b1);
    repeat (20) cyc(10'b1 << 5, 1'b1, 1'b0, 1'b0);
    cyc(10'd0, 1'b1, 1'b0, 1'b0);
    press(4);
    expect_all("hold5", 0, 5, 4, 2, 1, 0);

    // Two keys together are ignored; disabled press stays ignored when enable rises.
    cyc(10'd0, 1'b1, 1'b0, 1'b1);
    cyc(10'b0000100100, 1'b1, 1'b0, 1'b0);
    cyc(10'd0, 1'b1, 1'b0, 1'b0);
    press(2);
    expect_all("multi", 0, 0, 2, 1, 1, 0);
    cyc(10'b1 << 7, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(10'b1 << 7, 1'b1, 1'b0, 1'b0);
    cyc(10'd0, 1'b1, 1'b0, 1'b0);
    expect_all("dis7", 0, 0, 2, 1, 1, 0);

    // Four presses: oldest digit falls off, count saturates; start at count 0 ignored.
    cyc(10'd0, 1'b1, 1'b0, 1'b1);
    press(1); press(2); press(3); press(4);
    expect_all("p1234", 2, 3, 4, 3, 1, 0);
    cyc(10'd0, 1'b1, 1'b0, 1'b1);
    cyc(10'd0, 1'b1, 1'b1, 1'b0);
    expect_all("start0", 0, 0, 0, 0, 1, 0);

    // Reset during the load cycle wins.
    cyc(10'd0, 1'b0, 1'b0, 1'b0);
    press(1);
    cyc(10'd0, 1'b1, 1'b1, 1'b0);
    expect_all("clrload_pre", 0, 0, 1, 1, 0, 0);
    cyc(10'd0, 1'b1, 1'b1, 1'b1);
    expect_all("clrload", 0, 0, 0, 0, 1, 0);

    // Key held across reset release is accepted without a release.
    cyc(10'b1 << 6, 1'b1, 1'b0, 1'b1);
    cyc(10'b1 << 6, 1'b1, 1'b0, 1'b0);
    expect_all("clrheld", 0, 0, 6, 1, 1, 0);

    // Randomized traffic checked only against the model.
    prev = 10'd0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) k = 10'd0;
      else if (r < 8) k = 10'b1 << $urandom_range(0, 9);
      else if (r < 9) k = 10'($urandom);
      else k = prev;
      prev = k;
      cyc(k, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) == 0));
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: `clock` is the single clock, all state changes on its rising edge, and `clr` resets synchronously when high.
REQ-002 Port list:
- clock  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- key  in  10  keypad level inputs, bit n high = digit n held, already debounced.
- enable  in  1  entry permitted; the timer is idle.
- start  in  1  start-button level.
- mins  out  4  BCD minutes digit, feeds timer minutes counter data.
- tens  out  4  BCD seconds-tens digit, feeds timer tens counter data.
- ones  out  4  BCD seconds-ones digit, feeds timer ones counter data.
- loadn  out  1  active-low one-cycle load strobe to the timer counters.
- err  out  1  one-cycle pulse: start rejected.
- count  out  2  digits entered, saturating at 3.
REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 The FSM SHALL have three states: IDLE (armed), HELD (waiting for all keys released) and LOAD (strobe cycle).
REQ-005 In IDLE, when `enable`=1 and exactly one `key` bit n is high:
- mins<=tens, tens<=ones, ones<=n;
- count<=min(count+1,3);
- next state HELD.
REQ-006 In IDLE, when `key` has two or more bits high, or `enable`=0 with any bit high, the digits SHALL NOT change and the FSM SHALL go to HELD.
REQ-007 In HELD, the FSM SHALL return to IDLE on the first cycle with key==0; otherwise all key activity SHALL be ignored.
REQ-008 Each press SHALL shift in exactly one digit, regardless of how long it is held.
REQ-009 Shifting beyond three digits SHALL discard the old mins value, and count SHALL stay at 3.
REQ-010 In IDLE with key==0, enable=1, start=1 and count>0:
- if tens<=5, the FSM SHALL go to LOAD;
- if tens>5, err SHALL be 1 for the next cycle only, digits and count SHALL be kept, and the FSM SHALL stay in IDLE.
REQ-011 start with count==0, start with enable=0, or start while in HELD SHALL be ignored, with no err.
REQ-012 If key is nonzero and start=1 in the same IDLE cycle, the key SHALL take priority and start SHALL be ignored.
REQ-013 start SHALL be level-sampled only in IDLE; after LOAD, a still-high start SHALL NOT retrigger until count>0 again.
REQ-014 In LOAD, loadn SHALL be 0 for exactly one cycle, and mins/tens/ones SHALL hold the entered values during that cycle.
REQ-015 On LOAD exit:
- mins, tens and ones SHALL be cleared to 0;
- count SHALL be cleared to 0;
- loadn SHALL return to 1;
- the next state SHALL be HELD if key!=0, else IDLE.
REQ-016 Latency: the loadn low cycle SHALL begin one clock after the start sample; a shifted digit SHALL be visible one clock after the key sample.
REQ-017 Digits SHALL always be 0-9; no other code SHALL appear on mins, tens or ones.

Reset
REQ-018 With clr=1 at a rising edge, the next values SHALL be mins=tens=ones=0, count=0, loadn=1, err=0, state IDLE.
REQ-019 clr SHALL override every other input, including during LOAD: loadn SHALL be 1 on the cycle after the clr edge.
REQ-020 A key held while clr deasserts SHALL be accepted as a new press if exactly one bit is high and enable=1, with no release required.

Verification
REQ-021 Press 1, 3, 0 (each released between presses), then start -> mins=1, tens=3, ones=0, count=3; loadn=0 for one cycle; next cycle all digits=0, count=0.
REQ-022 Press 9, 9, release, then start -> tens=9; err pulses for 1 cycle; loadn stays 1; digits are retained.
REQ-023 Hold key[5] for 20 cycles, then press 4 -> ones=4, tens=5, count=2 (single capture per press).
REQ-024 Drive key=10'b0000100100, then release, then press 2 -> only ones=2, count=1; with enable=0, press 7 then raise enable while 7 is held -> no capture.
REQ-025 Press 1, 2, 3, 4 -> mins=2, tens=3, ones=4, count=3; start with count=0 -> no loadn, no err.
REQ-026 Assert clr during the LOAD cycle -> loadn=1 and all outputs zero on the next cycle.
